viterbi_decode_ctrl: RTL
========================

VITERBI_DECODE_CTRL -- requirements
Module: viterbi_decode_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16: trellis steps (code symbols) per frame; range 2..64.
REQ-002 SHALL have parameter PM_WIDTH, default 6: path-metric width in bits; range 4..12.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port st, input, 1 bit: frame start request.
REQ-006 SHALL have port data_in, input, 2 bits: received rate-1/2 code symbol.
REQ-007 SHALL have port in_valid, input, 1 bit: data_in holds a valid symbol.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a symbol this cycle.
REQ-009 SHALL have port dec_frame, output, FRAME_LEN bits: decoded bits; bit i is the bit of symbol i.
REQ-010 SHALL have port pm_min, output, PM_WIDTH bits: winning path metric of the last frame.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when dec_frame and pm_min are valid.

Function
REQ-013 SHALL implement FSM IDLE -> ACS -> TRACE -> DONE -> IDLE.
REQ-014 IDLE: on st=1 SHALL load path metrics PM0=0 and PM1..PM3=all ones, clear the step counter, and enter ACS.
REQ-015 SHALL ignore st outside IDLE.
REQ-016 in_ready SHALL equal 1 only in ACS.
REQ-017 SHALL accept a symbol on in_valid&&in_ready, performing one ACS step per accepted symbol.
REQ-018 SHALL compute branch metrics as 2-bit Hamming distances between data_in and the expected codes: state0 {p0:00, p1:11}, state1 {p2:10, p3:01}, state2 {p0:11, p1:00}, state3 {p2:01, p3:10}.
REQ-019 SHALL compute each candidate metric as PM[pred]+BM, saturating at 2^PM_WIDTH-1.
REQ-020 SHALL select the smaller candidate; on a tie, SHALL select the even predecessor.
REQ-021 SHALL store one decision bit per state per step (1 = odd predecessor) in a FRAME_LEN x 4 register array indexed by the step count.
REQ-022 After step FRAME_LEN-1 is accepted, SHALL enter TRACE on the next cycle.
REQ-023 SHALL not advance ACS while in_valid=0; stall length SHALL be unbounded.
REQ-024 TRACE: SHALL select the start state as the minimum-PM state, lowest index on a tie; SHALL latch its PM into pm_min.
REQ-025 TRACE: SHALL walk back one step per cycle for FRAME_LEN cycles; at step k in state n, SHALL write dec_frame[k]=n[1] and set prev = {n[0], decision[k][n]}.
REQ-026 DONE: SHALL assert done for exactly one cycle, then return to IDLE; done SHALL occur FRAME_LEN+1 cycles after entering TRACE.
REQ-027 dec_frame and pm_min SHALL hold their values until the next done.
REQ-028 SHALL accept st in the cycle immediately after DONE, giving back-to-back frames.

Reset
REQ-029 rst=1 SHALL force IDLE immediately, asynchronously, from any state, including mid-ACS and mid-TRACE.
REQ-030 While rst=1, SHALL hold in_ready=0, busy=0, done=0, dec_frame=0, pm_min=0, and clear path metrics, step counter and decision array to 0.
REQ-031 SHALL discard a partially received frame on reset and produce no done for it.

Configuration
REQ-032 With macro VITERBI_TAIL_ZERO_EN defined, traceback SHALL start from state 0 and pm_min SHALL be PM0, for encoder frames terminated with two zero tail bits.
REQ-033 Without VITERBI_TAIL_ZERO_EN, traceback SHALL start from the minimum-PM state per REQ-024.

Verification
REQ-034 FRAME_LEN=6, error-free symbols 11,10,00,01,01,11 with in_valid held high -> dec_frame=6'b001101 (bits 0..5 = 1,0,1,1,0,0), pm_min=0, done 7 cycles after TRACE entry.
REQ-035 Same frame with symbol 0 corrupted to 01, VITERBI_TAIL_ZERO_EN defined -> dec_frame bits 0..5 = 1,0,1,1,0,0 and pm_min=1.
REQ-036 Symbols of REQ-034 with in_valid deasserted 3 cycles between each symbol -> identical dec_frame and pm_min; in_ready stays high throughout ACS.
REQ-037 rst pulse after the third accepted symbol -> immediate IDLE with all outputs 0 and no done; a new st followed by the full frame then decodes correctly.
REQ-038 st pulsed during ACS and TRACE -> no effect; a second st the cycle after done -> second frame starts and decodes correctly.
REQ-039 PM_WIDTH=4, FRAME_LEN=16, all symbols 11 -> PM1..PM3 saturate at 15 without wrap, and pm_min is never above 15.

Source files
------------

// File: rtl/viterbi_decode_ctrl.sv
// Rate-1/2, 4-state Viterbi decoder: ACS per symbol, decision RAM, traceback.
// Define VITERBI_TAIL_ZERO_EN to start traceback at state 0 (zero-tailed frames).

module viterbi_acs_unit #(
  parameter int PM_WIDTH = 6,
  parameter int STATE    = 0
) (
  input  logic [1:0]          sym,
  input  logic [PM_WIDTH-1:0] pm_even,
  input  logic [PM_WIDTH-1:0] pm_odd,
  output logic [PM_WIDTH-1:0] pm_new,
  output logic                dec
);
  // The odd-predecessor code is always the complement of the even one.
  localparam logic [1:0] CODE_EVEN = (STATE == 0) ? 2'b00 :
                                     (STATE == 1) ? 2'b10 :
                                     (STATE == 2) ? 2'b11 : 2'b01;
  localparam logic [1:0] CODE_ODD  = ~CODE_EVEN;

  logic [1:0]          diff_e, diff_o;
  logic [PM_WIDTH:0]   sum_e, sum_o;
  logic [PM_WIDTH-1:0] cand_e, cand_o;

  assign diff_e = sym ^ CODE_EVEN;
  assign diff_o = sym ^ CODE_ODD;
  assign sum_e  = {1'b0, pm_even} + (PM_WIDTH+1)'(diff_e[0]) + (PM_WIDTH+1)'(diff_e[1]);
  assign sum_o  = {1'b0, pm_odd}  + (PM_WIDTH+1)'(diff_o[0]) + (PM_WIDTH+1)'(diff_o[1]);
  assign cand_e = sum_e[PM_WIDTH] ? '1 : sum_e[PM_WIDTH-1:0];
  assign cand_o = sum_o[PM_WIDTH] ? '1 : sum_o[PM_WIDTH-1:0];
  assign dec    = cand_o < cand_e;
  assign pm_new = dec ? cand_o : cand_e;
endmodule

module viterbi_decode_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int PM_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st,
  input  logic [1:0]           data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [FRAME_LEN-1:0] dec_frame,
  output logic [PM_WIDTH-1:0]  pm_min,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [PM_WIDTH-1:0] PM_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACS, TRACE, DONE} state_t;

  state_t                         state, state_nxt;
  logic [3:0][PM_WIDTH-1:0]       pm, pm_acs;
  logic [3:0]                     dec_step;
  logic [FRAME_LEN-1:0][3:0]      dec_mem;
  logic [CW-1:0]                  cnt;
  logic                           walk;
  logic [1:0]                     cur, start_st;
  logic [FRAME_LEN-1:0]           dec_shift;
  logic [PM_WIDTH-1:0]            pm_sel;
  logic                           last;

  for (genvar g = 0; g < 4; g++) begin : g_acs
    viterbi_acs_unit #(.PM_WIDTH(PM_WIDTH), .STATE(g)) u_acs (
      .sym     (data_in),
      .pm_even (pm[(g%2)*2]),
      .pm_odd  (pm[(g%2)*2+1]),
      .pm_new  (pm_acs[g]),
      .dec     (dec_step[g])
    );
  end

  assign last = (cnt == CW'(FRAME_LEN-1));

  always_comb begin
    start_st = 2'd0;
`ifndef VITERBI_TAIL_ZERO_EN
    for (int i = 1; i < 4; i++)
      if (pm[i] < pm[start_st]) start_st = 2'(i);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (st) state_nxt = ACS;
      end
      ACS: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nxt = TRACE;
      end
      TRACE: if (walk && cnt == '0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm        <= '0;
      dec_mem   <= '0;
      cnt       <= '0;
      walk      <= 1'b0;
      cur       <= '0;
      dec_shift <= '0;
      pm_sel    <= '0;
      dec_frame <= '0;
      pm_min    <= '0;
    end else begin
      case (state)
        IDLE: if (st) begin
          pm   <= {PM_MAX, PM_MAX, PM_MAX, {PM_WIDTH{1'b0}}};
          cnt  <= '0;
          walk <= 1'b0;
        end
        ACS: if (in_valid) begin
          pm           <= pm_acs;
          dec_mem[cnt] <= dec_step;
          if (!last) cnt <= cnt + 1'b1;
        end
        TRACE: begin
          // First cycle picks the survivor; the rest walk back one step each.
          if (!walk) begin
            cur    <= start_st;
            pm_sel <= pm[start_st];
            walk   <= 1'b1;
          end else begin
            dec_shift[cnt] <= cur[1];
            cur            <= {cur[0], dec_mem[cnt][cur]};
            if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
              dec_frame <= {dec_shift[FRAME_LEN-1:1], cur[1]};
              pm_min    <= pm_sel;
            end
          end
        end
        DONE: walk <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
